// File: rtl/tdm_pkg.sv
// Shared definitions for the 16:1 bit-serial TDM link (demux receiver and matching mux transmitter).
package tdm_pkg;
  localparam int NUM_SLOTS_DEF = 16;
  localparam int SLOT_W_DEF    = 4;

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } tdm_state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: increments on enable, wraps modulo 2**SLOT_W, with synchronous
// clear and load-to-1 (the slot after a frame-start bit). tc_o flags the last slot.
module tdm_slot_counter #(
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              load1_i,
  input  logic              clr_i,
  output logic [SLOT_W-1:0] cnt_o,
  output logic              tc_o
);
  logic [SLOT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = SLOT_W'(1);
    else if (en_i)    cnt_d = cnt_q + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == {SLOT_W{1'b1}});
endmodule

// File: rtl/tdm_demux16.sv
// 16:1 TDM receiver: locks onto frame_start, scatters serial bits into lanes and
// publishes each completed frame as a registered parallel word with a one-cycle valid.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = SLOT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [NUM_SLOTS-1:0] dout,
  output logic                 dout_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 frame_err
);
  tdm_state_e             state_q, state_d;
  // The last slot's bit goes straight into dout, so only NUM_SLOTS-1 bits are staged.
  logic [NUM_SLOTS-2:0]   asm_q, asm_d;
  logic [NUM_SLOTS-1:0]   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   cnt_en, cnt_load1, cnt_clr, cnt_tc;
  logic [SLOT_W-1:0]      slot_cnt;

  tdm_slot_counter #(.SLOT_W(SLOT_W)) u_slot_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (cnt_en),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .cnt_o   (slot_cnt),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_en       = 1'b0;
    cnt_load1    = 1'b0;
    cnt_clr      = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_start) begin
            asm_d[0]  = din;
            cnt_load1 = 1'b1;
            state_d   = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (frame_start) begin
            // A frame start anywhere but slot 0 abandons the partial frame and resyncs.
            frame_err_d = (slot_cnt != '0);
            asm_d[0]    = din;
            cnt_load1   = 1'b1;
          end else if (slot_cnt == '0) begin
            frame_err_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = HUNT;
          end else if (cnt_tc) begin
            dout_d       = {din, asm_q};
            dout_valid_d = 1'b1;
            cnt_en       = 1'b1;
          end else begin
            asm_d[slot_cnt] = din;
            cnt_en          = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_cnt;
  assign locked     = (state_q == ASSEMBLE);
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed testbench for tdm_demux16: reset, clean/back-to-back frames, stalls,
// early sync, missing sync and reset mid-frame.
module tb_tdm_demux16;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        frame_err;

  int n_cmp = 0;
  int n_mis = 0;

  tdm_demux16 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .slot        (slot),
    .locked      (locked),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of input, then let the edge happen and sample 1 ns after it.
  task automatic step(input logic v, input logic d, input logic fs);
    din_valid   = v;
    din         = d;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({dout_valid, frame_err} !== 2'b00) begin
        n_mis++;
        $display("FAIL reset_pulses cycle %0d: got %b required 00", c, {dout_valid, frame_err});
      end
    end
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_mis++;
      $display("FAIL reset_dout: got %h required 0000", dout);
    end
    n_cmp++;
    if (slot !== 4'd0) begin
      n_mis++;
      $display("FAIL reset_slot: got %0d required 0", slot);
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_locked: got %b required 0", locked);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clean_frame();
    logic [15:0] w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      if (i < 15) begin
        n_cmp++;
        if (dout_valid !== 1'b0 || slot !== 4'(i + 1) || locked !== 1'b1) begin
          n_mis++;
          $display("FAIL clean_progress slot %0d: got valid=%b slot=%0d locked=%b required 0/%0d/1",
                   i, dout_valid, slot, locked, i + 1);
        end
      end
    end
    n_cmp++;
    if (dout_valid !== 1'b1 || dout !== 16'hA5C3) begin
      n_mis++;
      $display("FAIL clean_publish: got valid=%b dout=%h required 1/a5c3", dout_valid, dout);
    end
    n_cmp++;
    if (slot !== 4'd0 || locked !== 1'b1) begin
      n_mis++;
      $display("FAIL clean_after: got slot=%0d locked=%b required 0/1", slot, locked);
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dout_valid !== 1'b0 || dout !== 16'hA5C3) begin
      n_mis++;
      $display("FAIL clean_pulse_width: got valid=%b dout=%h required 0/a5c3", dout_valid, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int pulse_k[$];
    logic [15:0] pulse_d[$];
    for (int k = 0; k < 32; k++) begin
      w = (k < 16) ? 16'h1234 : 16'hFFFF;
      step(1'b1, w[k % 16], (k % 16) == 0);
      if (dout_valid === 1'b1) begin
        pulse_k.push_back(k);
        pulse_d.push_back(dout);
      end
    end
    n_cmp++;
    if (pulse_k.size() != 2) begin
      n_mis++;
      $display("FAIL b2b_pulse_count: got %0d required 2", pulse_k.size());
    end else begin
      n_cmp++;
      if (pulse_k[0] != 15 || pulse_k[1] != 31) begin
        n_mis++;
        $display("FAIL b2b_pulse_pos: got %0d,%0d required 15,31", pulse_k[0], pulse_k[1]);
      end
      n_cmp++;
      if (pulse_d[0] !== 16'h1234 || pulse_d[1] !== 16'hFFFF) begin
        n_mis++;
        $display("FAIL b2b_data: got %h,%h required 1234,ffff", pulse_d[0], pulse_d[1]);
      end
    end
  endtask

  task automatic test_stalls();
    logic [15:0] w = 16'hA5C3;
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], i == 0);
      if (dout_valid === 1'b1) pulses++;
      if (i == 3 || i == 15) begin
        for (int s = 0; s < 2; s++) begin
          step(1'b0, ~w[i], 1'b1);
          if (dout_valid === 1'b1) pulses++;
          n_cmp++;
          if (slot !== 4'((i + 1) % 16) || locked !== 1'b1 || frame_err !== 1'b0) begin
            n_mis++;
            $display("FAIL stall_frozen after slot %0d: got slot=%0d locked=%b err=%b required %0d/1/0",
                     i, slot, locked, frame_err, (i + 1) % 16);
          end
        end
      end
    end
    n_cmp++;
    if (pulses != 1 || dout !== 16'hA5C3) begin
      n_mis++;
      $display("FAIL stall_result: got pulses=%0d dout=%h required 1/a5c3", pulses, dout);
    end
  endtask

  task automatic test_early_sync();
    logic [15:0] junk = 16'h3C3C;
    logic [15:0] w = 16'h00FF;
    for (int i = 0; i < 7; i++) step(1'b1, junk[i], i == 0);
    n_cmp++;
    if (slot !== 4'd7) begin
      n_mis++;
      $display("FAIL early_pre_slot: got %0d required 7", slot);
    end
    step(1'b1, w[0], 1'b1);
    n_cmp++;
    if (frame_err !== 1'b1 || dout_valid !== 1'b0 || slot !== 4'd1 || locked !== 1'b1) begin
      n_mis++;
      $display("FAIL early_err: got err=%b valid=%b slot=%0d locked=%b required 1/0/1/1",
               frame_err, dout_valid, slot, locked);
    end
    n_cmp++;
    if (dout !== 16'hA5C3) begin
      n_mis++;
      $display("FAIL early_dout_hold: got %h required a5c3", dout);
    end
    step(1'b1, w[1], 1'b0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_mis++;
      $display("FAIL early_err_width: got %b required 0", frame_err);
    end
    for (int i = 2; i < 16; i++) step(1'b1, w[i], 1'b0);
    n_cmp++;
    if (dout_valid !== 1'b1 || dout !== 16'h00FF) begin
      n_mis++;
      $display("FAIL early_recover: got valid=%b dout=%h required 1/00ff", dout_valid, dout);
    end
  endtask

  task automatic test_missing_sync();
    logic [15:0] w = 16'h5A69;
    int pulses = 0;
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || slot !== 4'd0 || dout_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL miss_err: got err=%b locked=%b slot=%0d valid=%b required 1/0/0/0",
               frame_err, locked, slot, dout_valid);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i), 1'b0);
    n_cmp++;
    if (frame_err !== 1'b0 || locked !== 1'b0 || slot !== 4'd0 || dout !== 16'h00FF) begin
      n_mis++;
      $display("FAIL miss_hunt: got err=%b locked=%b slot=%0d dout=%h required 0/0/0/00ff",
               frame_err, locked, slot, dout);
    end
    for (int i = 0; i < 16; i++) step(1'b1, w[i], i == 0);
    n_cmp++;
    if (dout_valid !== 1'b1 || dout !== 16'h5A69) begin
      n_mis++;
      $display("FAIL miss_relock: got valid=%b dout=%h required 1/5a69", dout_valid, dout);
    end
    // Reset at slot 9, then feed the rest of the frame without a frame start.
    for (int i = 0; i < 9; i++) step(1'b1, w[i], i == 0);
    rst = 1'b1;
    step(1'b1, w[9], 1'b0);
    rst = 1'b0;
    n_cmp++;
    if (dout !== 16'h0000 || locked !== 1'b0 || slot !== 4'd0 || dout_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_mid: got dout=%h locked=%b slot=%0d valid=%b required 0000/0/0/0",
               dout, locked, slot, dout_valid);
    end
    for (int i = 10; i < 16; i++) begin
      step(1'b1, w[i], 1'b0);
      if (dout_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || dout !== 16'h0000 || locked !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_discard: got pulses=%0d dout=%h locked=%b required 0/0000/0",
               pulses, dout, locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_stalls();
    test_early_sync();
    test_missing_sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
